// File: rtl/weapon_fire_scheduler.sv
// Fire scheduler between turret requesters and the ammo saturation counter.
// It grants requests round-robin, enforces a cooldown after each shot and runs timed reloads.
module weapon_fire_scheduler #(
   parameter int         N_REQ       = 4,
   parameter int         AW          = 9,
   parameter int         CW          = 8,
   parameter int         RELOAD_CYC  = 16,
   parameter logic [3:0] ATTACK_MODE = 4'b0010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       mode,
   input  logic [N_REQ-1:0] req,
   input  logic [AW-1:0]    fire_rate,
   input  logic [CW-1:0]    cooldown,
   input  logic             reload_req,
   input  logic [AW-1:0]    reload_amt,
   input  logic [AW-1:0]    max_ammo,
   input  logic [AW-1:0]    ammo_count,
   output logic [N_REQ-1:0] grant,
   output logic             ctr_down,
   output logic [AW-1:0]    ctr_rate,
   output logic             ctr_load,
   output logic             ctr_load_max,
   output logic [AW-1:0]    ctr_in,
   output logic             busy,
   output logic             error,
   output logic [1:0]       err_cause
);

   // state    | meaning
   // S_INIT    | first cycle after reset release
   // S_LOADMAX | load magazine capacity into the counter max register
   // S_IDLE    | evaluate reload / fire requests, flag errors
   // S_FIRE    | one-cycle grant and decrement strobe
   // S_COOLDOWN| post-shot idle time, requests held pending
   // S_RELOAD  | timed reload, counter load in the last cycle

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int RW = $clog2(RELOAD_CYC + 1);
   localparam logic [RW-1:0] RC_INIT  = RW'(RELOAD_CYC - 1);
   localparam logic [PW-1:0] PTR_INIT = PW'(N_REQ - 1);

   typedef enum logic [2:0] {
      S_INIT, S_LOADMAX, S_IDLE, S_FIRE, S_COOLDOWN, S_RELOAD
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cd_q, cd_d;
   logic [RW-1:0]   rc_q, rc_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [AW-1:0]   amt_q, amt_d;

   logic [PW-1:0]   win_idx;
   logic            win_valid;
   logic            req_any, mode_ok, ammo_low;

   logic [N_REQ-1:0] grant_d;
   logic             down_d, load_d, load_max_d, busy_d, error_d;
   logic [AW-1:0]    rate_d, in_d;
   logic [1:0]       cause_d;

   assign req_any  = |req;
   assign mode_ok  = (mode == ATTACK_MODE);
   assign ammo_low = (ammo_count == '0) || (ammo_count < fire_rate);

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      logic [PW-1:0] idx;
      win_valid = 1'b0;
      win_idx   = '0;
      idx       = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = PW'((int'(ptr_q) + i) % N_REQ);
         if (!win_valid && req[idx]) begin
            win_valid = 1'b1;
            win_idx   = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_INIT;
         cd_q    <= '0;
         rc_q    <= '0;
         ptr_q   <= PTR_INIT;
         amt_q   <= '0;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         rc_q    <= rc_d;
         ptr_q   <= ptr_d;
         amt_q   <= amt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      rc_d    = rc_q;
      ptr_d   = ptr_q;
      amt_d   = amt_q;
      case (state_q)
         S_INIT:    state_d = S_LOADMAX;
         S_LOADMAX: state_d = S_IDLE;
         S_IDLE: begin
            if (reload_req) begin
               state_d = S_RELOAD;
               amt_d   = reload_amt;
               rc_d    = RC_INIT;
            end else if (req_any && mode_ok && !ammo_low && win_valid) begin
               state_d = S_FIRE;
               ptr_d   = win_idx;
            end
         end
         S_FIRE: begin
            if (cooldown == '0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_COOLDOWN;
               cd_d    = cooldown;
            end
         end
         S_COOLDOWN: begin
            if (cd_q <= CW'(1)) state_d = S_IDLE;
            else                cd_d    = cd_q - CW'(1);
         end
         S_RELOAD: begin
            if (rc_q == '0) state_d = S_IDLE;
            else            rc_d    = rc_q - RW'(1);
         end
         default:   state_d = S_INIT;
      endcase
   end

   // Outputs are registered: this computes what they must show in the next state.
   always_comb begin
      grant_d    = '0;
      down_d     = 1'b0;
      rate_d     = ctr_rate;
      load_d     = 1'b0;
      load_max_d = 1'b0;
      in_d       = '0;
      busy_d     = (state_d != S_IDLE);
      error_d    = 1'b0;
      cause_d    = 2'b00;
      case (state_q)
         S_INIT: begin
            load_max_d = 1'b1;
            in_d       = max_ammo;
         end
         S_IDLE: begin
            if (reload_req) begin
               if (RELOAD_CYC == 1) begin
                  load_d = 1'b1;
                  in_d   = reload_amt;
               end
            end else if (req_any) begin
               if (!mode_ok) begin
                  error_d = 1'b1;
                  cause_d = 2'b01;
               end else if (ammo_low) begin
                  error_d = 1'b1;
                  cause_d = 2'b10;
               end else if (win_valid) begin
                  grant_d = N_REQ'(1) << win_idx;
                  down_d  = 1'b1;
                  rate_d  = fire_rate;
               end
            end
         end
         S_RELOAD: begin
            if (rc_q == RW'(1)) begin
               load_d = 1'b1;
               in_d   = amt_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant        <= '0;
         ctr_down     <= 1'b0;
         ctr_rate     <= '0;
         ctr_load     <= 1'b0;
         ctr_load_max <= 1'b0;
         ctr_in       <= '0;
         busy         <= 1'b0;
         error        <= 1'b0;
         err_cause    <= 2'b00;
      end else begin
         grant        <= grant_d;
         ctr_down     <= down_d;
         ctr_rate     <= rate_d;
         ctr_load     <= load_d;
         ctr_load_max <= load_max_d;
         ctr_in       <= in_d;
         busy         <= busy_d;
         error        <= error_d;
         err_cause    <= cause_d;
      end
   end

endmodule

// File: tb/tb_weapon_fire_scheduler.sv
// Directed bench for weapon_fire_scheduler: startup, firing cadence, round-robin,
// errors, reload timing and reset during reload.
module tb_weapon_fire_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] mode = 4'd0;
   logic [3:0] req = 4'd0;
   logic [8:0] fire_rate = 9'd0;
   logic [7:0] cooldown = 8'd0;
   logic       reload_req = 1'b0;
   logic [8:0] reload_amt = 9'd0;
   logic [8:0] max_ammo = 9'd300;
   logic [8:0] ammo_count = 9'd300;

   logic [3:0] grant;
   logic       ctr_down, ctr_load, ctr_load_max, busy, error;
   logic [8:0] ctr_rate, ctr_in;
   logic [1:0] err_cause;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] rr_exp [8];

   weapon_fire_scheduler #(
      .N_REQ(4), .AW(9), .CW(8), .RELOAD_CYC(16), .ATTACK_MODE(4'b0010)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .req(req), .fire_rate(fire_rate),
      .cooldown(cooldown), .reload_req(reload_req), .reload_amt(reload_amt),
      .max_ammo(max_ammo), .ammo_count(ammo_count), .grant(grant),
      .ctr_down(ctr_down), .ctr_rate(ctr_rate), .ctr_load(ctr_load),
      .ctr_load_max(ctr_load_max), .ctr_in(ctr_in), .busy(busy),
      .error(error), .err_cause(err_cause)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rr_exp = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};

      // reset state and startup
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_load_max", 32'(ctr_load_max), 0);
      check("rst_in", 32'(ctr_in), 0);
      rst = 1'b1;
      @(negedge clk);
      check("lm_strobe", 32'(ctr_load_max), 1);
      check("lm_in", 32'(ctr_in), 300);
      check("lm_busy", 32'(busy), 1);
      @(negedge clk);
      check("lm_once", 32'(ctr_load_max), 0);
      check("lm_in_clr", 32'(ctr_in), 0);
      check("idle_busy", 32'(busy), 0);

      // single requester, cooldown 3 -> shot every 5 cycles
      mode = 4'b0010; ammo_count = 9'd300; fire_rate = 9'd5; cooldown = 8'd3; req = 4'b0001;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         check("cad_grant", 32'(grant), (k % 5 == 0) ? 1 : 0);
         check("cad_down", 32'(ctr_down), (k % 5 == 0) ? 1 : 0);
         check("cad_busy", 32'(busy), (k % 5 == 4) ? 0 : 1);
         check("cad_rate", 32'(ctr_rate), 5);
      end
      req = 4'b0000;
      repeat (5) @(negedge clk);

      // round-robin among 0,1,3 with cooldown 0, pointer currently at 0
      cooldown = 8'd0; req = 4'b1011;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("rr_grant", 32'(grant), 32'(rr_exp[j]));
      end
      req = 4'b0000;

      // wrong mode error
      mode = 4'b0001; req = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("wm_error", 32'(error), 1);
         check("wm_cause", 32'(err_cause), 1);
         check("wm_grant", 32'(grant), 0);
      end
      // insufficient ammo
      mode = 4'b0010; ammo_count = 9'd2; fire_rate = 9'd3;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("ia_error", 32'(error), 1);
         check("ia_cause", 32'(err_cause), 2);
         check("ia_down", 32'(ctr_down), 0);
      end
      // ammo equal to rate is legal
      ammo_count = 9'd3;
      @(negedge clk);
      check("eq_grant", 32'(grant), 4'b0100);
      check("eq_down", 32'(ctr_down), 1);
      check("eq_error", 32'(error), 0);
      check("eq_rate", 32'(ctr_rate), 3);
      req = 4'b0000;
      @(negedge clk);

      // reload wins over a simultaneous fire request
      reload_req = 1'b1; reload_amt = 9'd150; req = 4'b0001; ammo_count = 9'd300; fire_rate = 9'd5;
      for (int r = 1; r <= 16; r++) begin
         @(negedge clk);
         check("rl_busy", 32'(busy), 1);
         check("rl_load", 32'(ctr_load), (r == 16) ? 1 : 0);
         check("rl_in", 32'(ctr_in), (r == 16) ? 150 : 0);
         check("rl_error", 32'(error), 0);
         check("rl_grant", 32'(grant), 0);
         if (r == 1) reload_req = 1'b0;
      end
      @(negedge clk);
      check("rl_done_busy", 32'(busy), 0);
      check("rl_done_load", 32'(ctr_load), 0);
      @(negedge clk);
      check("rl_first_grant", 32'(grant), 1);
      check("rl_first_rate", 32'(ctr_rate), 5);
      req = 4'b0000;
      @(negedge clk);

      // reset in reload cycle 8
      reload_req = 1'b1; reload_amt = 9'd77;
      for (int r = 1; r <= 8; r++) begin
         @(negedge clk);
         if (r == 1) reload_req = 1'b0;
      end
      check("rr8_busy", 32'(busy), 1);
      #2 rst = 1'b0;
      #1;
      check("ar_busy", 32'(busy), 0);
      check("ar_load", 32'(ctr_load), 0);
      check("ar_in", 32'(ctr_in), 0);
      check("ar_rate", 32'(ctr_rate), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("ar_hold_load", 32'(ctr_load), 0);
         check("ar_hold_busy", 32'(busy), 0);
      end
      mode = 4'b0010; cooldown = 8'd0; ammo_count = 9'd300; req = 4'b0011;
      rst = 1'b1;
      @(negedge clk);
      check("re_lm", 32'(ctr_load_max), 1);
      check("re_lm_in", 32'(ctr_in), 300);
      check("re_load", 32'(ctr_load), 0);
      @(negedge clk);
      check("re_idle_busy", 32'(busy), 0);
      @(negedge clk);
      check("re_ptr_grant", 32'(grant), 1);
      req = 4'b0000;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
